// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word-addressed SRAM responder behind valid/ready request and response channels
//
// Optional feature macro: MEM_RESP_LFSR_DELAY_EN (adds 0..3 pseudo-random wait cycles per request)
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous active-high reset
//   req_valid  in   1   request present
//   req_ready  out  1   responder idle and able to accept
//   req_wen    in   1   1 = write, 0 = read
//   req_addr   in   32  byte address, low two bits ignored
//   req_wdata  in   32  write data
//   req_wmask  in   4   byte enables for writes
//   rsp_valid  out  1   response present
//   rsp_ready  in   1   initiator accepts response
//   rsp_rdata  out  32  read data, 0 for writes and errors
//   rsp_err    out  1   address out of range
module mem_responder #(
    parameter int          DEPTH   = 1024,
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int          LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef MEM_RESP_LFSR_DELAY_EN
    // one extra bit so LATENCY plus the random extra never overflows
    localparam int CW = 9;
`else
    localparam int CW = 8;
`endif

    if (LATENCY < 0 || LATENCY > 255) begin : g_bad_latency
        $error("mem_responder: LATENCY must be in 0..255");
    end

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          wen_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wmask_q;
    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic [CW-1:0] wait_cyc;
    logic          commit;
    logic          cur_wen;
    logic [31:0]   cur_addr;
    logic [31:0]   cur_wdata;
    logic [3:0]    cur_wmask;
    logic [31:0]   off;
    logic          in_range;
    logic [AW-1:0] idx;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && (state == IDLE);

`ifdef MEM_RESP_LFSR_DELAY_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    // extra wait comes from the LFSR value seen at accept time
    assign wait_cyc = CW'(LATENCY) + CW'(lfsr[1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else if (accept) begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end
`else
    assign wait_cyc = CW'(LATENCY);
`endif

    // zero-wait requests commit straight from the request bus
    assign commit    = ((state == BUSY) && (cnt == '0)) || (accept && (wait_cyc == '0));
    assign cur_wen   = (state == IDLE) ? req_wen   : wen_q;
    assign cur_addr  = (state == IDLE) ? req_addr  : addr_q;
    assign cur_wdata = (state == IDLE) ? req_wdata : wdata_q;
    assign cur_wmask = (state == IDLE) ? req_wmask : wmask_q;

    // byte offset compared against the byte size, so addr[1:0] never matters
    assign off      = cur_addr - BASE;
    assign in_range = (cur_addr >= BASE) && ({1'b0, off} < (33'(DEPTH) << 2));
    assign idx      = off[AW+1:2];

    // array write; gated by rst so an edge during reset cannot commit a dropped write
    always_ff @(posedge clk) begin
        if (!rst && commit && cur_wen && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_wmask[b]) begin
                    mem[idx][8*b +: 8] <= cur_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            wen_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        wen_q   <= req_wen;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        wmask_q <= req_wmask;
                        if (wait_cyc == '0) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= !in_range;
                            rsp_rdata <= (!cur_wen && in_range) ? mem[idx] : 32'h0;
                        end else begin
                            state <= BUSY;
                            cnt   <= wait_cyc - CW'(1);
                        end
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= !in_range;
                        rsp_rdata <= (!cur_wen && in_range) ? mem[idx] : 32'h0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized self-checking bench for mem_responder against a behavioural memory model
module tb_mem_responder;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          LAT   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] model_mem [DEPTH];

    mem_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_wen  (req_wen),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_wmask(req_wmask),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // memory semantics: byte array starting at BASE, DEPTH words long
    task automatic model_access(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] wmask, output logic [31:0] exp_rd, output logic exp_err);
        longint off;
        int     w;
        off = longint'(addr) - longint'(BASE);
        exp_rd  = 32'h0;
        exp_err = 1'b0;
        if (off < 0 || off >= longint'(DEPTH) * 4) begin
            exp_err = 1'b1;
        end else begin
            w = int'(off / 4);
            if (wen) begin
                for (int b = 0; b < 4; b++)
                    if (wmask[b]) model_mem[w][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                exp_rd = model_mem[w];
            end
        end
    endtask

    task automatic check_lat(input string tag, input int lat);
`ifdef MEM_RESP_LFSR_DELAY_EN
        check(tag, 32'((lat >= LAT && lat <= LAT + 3) ? 1 : 0), 32'd1);
`else
        check(tag, 32'(lat), 32'(LAT));
`endif
    endtask

    // one transaction with rsp_ready held high; lat = edges from accept to rsp_valid visible
    task automatic txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wmask, output logic [31:0] rd, output logic er, output int lat);
        rsp_ready = 1'b1;
        @(negedge clk);
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = wmask;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wdata = $urandom;
        lat = 0;
        while (!rsp_valid && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        @(posedge clk);
        #1;
    endtask

    task automatic do_check(input string tag, input logic wen, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wmask, output logic [31:0] rd);
        logic [31:0] exp_rd;
        logic        exp_err;
        logic        er;
        int          lat;
        txn(wen, addr, wdata, wmask, rd, er, lat);
        model_access(wen, addr, wdata, wmask, exp_rd, exp_err);
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_err"}, 32'(er), 32'(exp_err));
        check_lat({tag, "_lat"}, lat);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] cap;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [31:0] a;
        int          n;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_wen   = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;
        rsp_ready = 1'b1;

        // reset with garbage on the inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_valid = 1'($urandom);
            req_wen   = 1'($urandom);
            req_addr  = $urandom;
            req_wdata = $urandom;
            req_wmask = 4'($urandom);
            rsp_ready = 1'($urandom);
        end
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        rst       = 1'b0;

        // fill the whole array so every later read has a defined expectation
        for (int i = 0; i < DEPTH; i++)
            do_check("init", 1'b1, BASE + 32'(i) * 4, $urandom, 4'hF, rd);

        do_check("wr_beef", 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, rd);
        check("wr_beef_zero", rd, 32'h0);
        do_check("rd_beef", 1'b0, 32'h8000_0010, 32'h0, 4'h0, rd);
        check("rd_beef_const", rd, 32'hDEAD_BEEF);
        do_check("wr_byte", 1'b1, 32'h8000_0010, 32'h1122_3344, 4'b0010, rd);
        do_check("rd_byte", 1'b0, 32'h8000_0013, 32'h0, 4'h0, rd);
        check("rd_byte_const", rd, 32'hDEAD_33EF);

        // backpressure: response must hold while rsp_ready is low
        rsp_ready = 1'b0;
        @(negedge clk);
        req_wen   = 1'b0;
        req_addr  = 32'h8000_0010;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_lat("bp_lat", n);
        model_access(1'b0, 32'h8000_0010, 32'h0, 4'h0, exp_rd, exp_err);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rdata", rsp_rdata, exp_rd);
            check("bp_err", 32'(rsp_err), 32'd0);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_rel_valid", 32'(rsp_valid), 32'd0);
        check("bp_rel_ready", 32'(req_ready), 32'd1);
        check("bp_rel_rdata", rsp_rdata, 32'h0);

        // out of range on both sides
        do_check("oor_lo", 1'b1, 32'h7FFF_FFFC, 32'h5555_AAAA, 4'hF, rd);
        check("oor_lo_errc", 32'(rsp_err), 32'd0);
        do_check("oor_hi", 1'b0, 32'h8000_1000, 32'h0, 4'h0, rd);
        check("oor_hi_rd0", rd, 32'h0);
        do_check("word0", 1'b0, BASE, 32'h0, 4'h0, rd);
        do_check("word1023", 1'b0, BASE + 32'(DEPTH - 1) * 4, 32'h0, 4'h0, rd);

        // abort a write while BUSY
        @(negedge clk);
        req_wen   = 1'b1;
        req_addr  = 32'h8000_0020;
        req_wdata = 32'hCAFE_F00D;
        req_wmask = 4'hF;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_valid_rst", 32'(rsp_valid), 32'd0);
        check("abort_ready_rst", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        do_check("abort_rd", 1'b0, 32'h8000_0020, 32'h0, 4'h0, rd);

        // randomized traffic, including back-to-back reads for the LFSR build
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(7, 0))
                0: a = BASE - 32'($urandom_range(16, 1));
                1: a = BASE + 32'(DEPTH) * 4 + 32'($urandom_range(64, 0));
                2: a = $urandom;
                default: a = BASE + 32'($urandom_range(DEPTH - 1, 0)) * 4 + 32'($urandom_range(3, 0));
            endcase
            do_check("rand", 1'($urandom), a, $urandom, 4'($urandom), rd);
        end

`ifdef MEM_RESP_LFSR_DELAY_EN
        for (int i = 0; i < 8; i++)
            do_check("lfsr_rd", 1'b0, BASE + 32'($urandom_range(DEPTH - 1, 0)) * 4, 32'h0, 4'h0, rd);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
